load_store_unit: RTL and testbench

//   Multi-cycle data-memory access unit for the RV32I core; produces the data_mem operand consumed by the

---
 rtl/lsu_pkg.sv | 40 ++++
 rtl/lsu_load_align.sv | 28 ++
 rtl/load_store_unit.sv | 150 +++++++++++++++
 tb/tb_load_store_unit.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: FSM state encoding, RV32I
// width codes, access legality and byte-enable generation.
package lsu_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        DONE = 3'd3,
        ERR  = 3'd4
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Unsigned widths exist only for loads; halves need even, words need 4-byte alignment.
    function automatic logic lsu_is_legal(input logic we, input logic [2:0] f3,
                                          input logic [1:0] off);
        case (f3)
            F3_B:    return 1'b1;
            F3_H:    return ~off[0];
            F3_W:    return (off == 2'b00);
            F3_BU:   return ~we;
            F3_HU:   return ~we & ~off[0];
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] lsu_byte_en(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            F3_B, F3_BU: return 4'b0001 << off;
            F3_H, F3_HU: return 4'b0011 << off;
            default:     return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load alignment: shifts the read word down to the addressed
// lane and sign/zero-extends according to the RV32I load width.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_offset,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data
);

    logic [31:0] w_shifted;

    assign w_shifted = i_rdata >> {i_offset, 3'b000};

    always_comb begin
        o_data = '0;
        case (i_funct3)
            F3_B:    o_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
            F3_H:    o_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
            F3_W:    o_data = w_shifted;
            F3_BU:   o_data = {24'b0, w_shifted[7:0]};
            F3_HU:   o_data = {16'b0, w_shifted[15:0]};
            default: o_data = '0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle RV32I load/store unit on a req/gnt/rvalid bus.
// Optional abort timer enabled by defining LSU_TIMEOUT_EN.
//
//   state | meaning
//   IDLE  | ready for a new access
//   REQ   | mem_req asserted, waiting for mem_gnt
//   WAIT  | granted, waiting for mem_rvalid
//   DONE  | one-cycle completion pulse
//   ERR   | one-cycle completion pulse with lsu_err (illegal or timed out)
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              lsu_valid,
    output logic              lsu_ready,
    input  logic              lsu_we,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              lsu_done,
    output logic [31:0]       load_data,
    output logic              lsu_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata
);

    lsu_state_e        r_state;
    logic              r_we;
    logic [2:0]        r_funct3;
    logic [1:0]        r_off;
    logic [31:0]       r_load_data;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [3:0]        r_mem_be;
    logic [31:0]       r_mem_wdata;

    logic              w_legal;
    logic              w_accept;
    logic              w_tmo_hit;
    logic [31:0]       w_aligned;
    logic [31:0]       w_load_val;

    assign w_legal    = lsu_is_legal(lsu_we, funct3, addr[1:0]);
    assign w_accept   = (r_state == IDLE) && lsu_valid;
    assign w_load_val = r_we ? 32'b0 : w_aligned;

    lsu_load_align u_align (
        .i_rdata  (mem_rdata),
        .i_offset (r_off),
        .i_funct3 (r_funct3),
        .o_data   (w_aligned)
    );

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_tmo_cnt;

    // Loaded on accept so the terminal count lands after TIMEOUT_CYCLES busy cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tmo_cnt <= '0;
        end else if (w_accept && w_legal) begin
            r_tmo_cnt <= CNT_W'(TIMEOUT_CYCLES - 1);
        end else if (r_state == IDLE) begin
            r_tmo_cnt <= '0;
        end else if (r_tmo_cnt != '0) begin
            r_tmo_cnt <= r_tmo_cnt - 1'b1;
        end
    end

    assign w_tmo_hit = ((r_state == REQ) || (r_state == WAIT)) && (r_tmo_cnt == '0);
`else
    logic w_unused_tmo;

    assign w_unused_tmo = (TIMEOUT_CYCLES == 0);
    assign w_tmo_hit    = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_we        <= 1'b0;
            r_funct3    <= '0;
            r_off       <= '0;
            r_load_data <= '0;
            r_mem_addr  <= '0;
            r_mem_be    <= '0;
            r_mem_wdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept && w_legal) begin
                        r_state     <= REQ;
                        r_we        <= lsu_we;
                        r_funct3    <= funct3;
                        r_off       <= addr[1:0];
                        r_mem_addr  <= {addr[ADDR_W-1:2], 2'b00};
                        r_mem_be    <= lsu_byte_en(funct3, addr[1:0]);
                        r_mem_wdata <= lsu_we ? (wdata << {addr[1:0], 3'b000}) : 32'b0;
                    end else if (w_accept) begin
                        r_state     <= ERR;
                        r_load_data <= '0;
                    end
                end
                REQ: begin
                    if (mem_gnt && mem_rvalid) begin
                        r_state     <= DONE;
                        r_load_data <= w_load_val;
                    end else if (mem_gnt) begin
                        r_state <= WAIT;
                    end else if (w_tmo_hit) begin
                        r_state     <= ERR;
                        r_load_data <= '0;
                    end
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        r_state     <= DONE;
                        r_load_data <= w_load_val;
                    end else if (w_tmo_hit) begin
                        r_state     <= ERR;
                        r_load_data <= '0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign lsu_ready = (r_state == IDLE);
    assign lsu_done  = (r_state == DONE) || (r_state == ERR);
    assign lsu_err   = (r_state == ERR);
    assign load_data = r_load_data;
    assign mem_req   = (r_state == REQ);
    assign mem_we    = r_we;
    assign mem_addr  = r_mem_addr;
    assign mem_be    = r_mem_be;
    assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: vector table for single accesses,
// hand sequences for stalls, resets and (with LSU_TIMEOUT_EN) the abort timer.
module tb_load_store_unit;
    import lsu_pkg::*;

`ifdef LSU_TIMEOUT_EN
    localparam int TMO = 4;
`else
    localparam int TMO = 16;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        lsu_valid = 1'b0;
    logic        lsu_ready;
    logic        lsu_we = 1'b0;
    logic [2:0]  funct3 = 3'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        lsu_done;
    logic [31:0] load_data;
    logic        lsu_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_W(32), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .lsu_valid(lsu_valid), .lsu_ready(lsu_ready),
        .lsu_we(lsu_we), .funct3(funct3), .addr(addr), .wdata(wdata),
        .lsu_done(lsu_done), .load_data(load_data), .lsu_err(lsu_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata)
    );

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        logic [3:0]  be;
        logic [31:0] mwdata;
        logic [31:0] load;
    } vec_t;

    typedef struct {
        logic        err;
        logic [31:0] load;
    } exp_t;

    vec_t vecs[14];
    exp_t sb_q[$];
    exp_t sb_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Scoreboard: every completion pulse must match the oldest pushed expectation.
    always @(negedge clk) begin
        if (!rst && lsu_done) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_done: got lsu_done=1 expected no completion");
            end else begin
                sb_e = sb_q.pop_front();
                chk("sb_load_data", load_data, sb_e.load);
                chk("sb_lsu_err", {31'b0, lsu_err}, {31'b0, sb_e.err});
            end
        end
    end

    task automatic drive_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] wd);
        lsu_valid = 1'b1;
        lsu_we    = we;
        funct3    = f3;
        addr      = a;
        wdata     = wd;
    endtask

    task automatic run_vec(input vec_t v);
        exp_t e;
        @(negedge clk);
        chk("ready_before", {31'b0, lsu_ready}, 32'd1);
        drive_req(v.we, v.f3, v.addr, v.wdata);
        e.err  = v.err;
        e.load = v.load;
        sb_q.push_back(e);
        @(negedge clk);
        lsu_valid = 1'b0;
        if (v.err) begin
            chk("err_no_req", {31'b0, mem_req}, 32'd0);
            chk("err_done", {30'b0, lsu_done, lsu_err}, 32'd3);
        end else begin
            chk("req", {31'b0, mem_req}, 32'd1);
            chk("ready_busy", {31'b0, lsu_ready}, 32'd0);
            chk("mem_addr", mem_addr, v.addr & 32'hFFFF_FFFC);
            chk("mem_we", {31'b0, mem_we}, {31'b0, v.we});
            chk("mem_be", {28'b0, mem_be}, {28'b0, v.be});
            chk("mem_wdata", mem_wdata, v.mwdata);
            mem_gnt = 1'b1;
            @(negedge clk);
            mem_gnt    = 1'b0;
            chk("req_dropped", {31'b0, mem_req}, 32'd0);
            chk("no_early_done", {31'b0, lsu_done}, 32'd0);
            mem_rvalid = 1'b1;
            mem_rdata  = v.rdata;
            @(negedge clk);
            mem_rvalid = 1'b0;
            mem_rdata  = 32'h5A5A_5A5A;
            chk("done_n3", {30'b0, lsu_done, lsu_err}, 32'd2);
        end
        @(negedge clk);
        chk("done_pulse_end", {30'b0, lsu_done, lsu_ready}, 32'd1);
    endtask

    initial begin
        exp_t e;
        int   k;

        vecs[0]  = '{1'b0, F3_W,  32'h100, 32'h0,        32'hDEADBEEF, 1'b0, 4'hF, 32'h0,        32'hDEADBEEF};
        vecs[1]  = '{1'b0, F3_B,  32'h103, 32'h0,        32'h80123456, 1'b0, 4'h8, 32'h0,        32'hFFFFFF80};
        vecs[2]  = '{1'b0, F3_BU, 32'h103, 32'h0,        32'h80123456, 1'b0, 4'h8, 32'h0,        32'h00000080};
        vecs[3]  = '{1'b1, F3_H,  32'h102, 32'h1234ABCD, 32'hFFFFFFFF, 1'b0, 4'hC, 32'hABCD0000, 32'h0};
        vecs[4]  = '{1'b0, F3_W,  32'h101, 32'h0,        32'h0,        1'b1, 4'h0, 32'h0,        32'h0};
        vecs[5]  = '{1'b0, F3_H,  32'h102, 32'h0,        32'h80011234, 1'b0, 4'hC, 32'h0,        32'hFFFF8001};
        vecs[6]  = '{1'b0, F3_HU, 32'h100, 32'h0,        32'h9999F00D, 1'b0, 4'h3, 32'h0,        32'h0000F00D};
        vecs[7]  = '{1'b1, F3_B,  32'h101, 32'h000000A5, 32'h0,        1'b0, 4'h2, 32'h0000A500, 32'h0};
        vecs[8]  = '{1'b1, F3_W,  32'h204, 32'hCAFEF00D, 32'h0,        1'b0, 4'hF, 32'hCAFEF00D, 32'h0};
        vecs[9]  = '{1'b1, F3_BU, 32'h200, 32'h11,       32'h0,        1'b1, 4'h0, 32'h0,        32'h0};
        vecs[10] = '{1'b0, 3'b011, 32'h200, 32'h0,       32'h0,        1'b1, 4'h0, 32'h0,        32'h0};
        vecs[11] = '{1'b1, F3_H,  32'h101, 32'h1234,     32'h0,        1'b1, 4'h0, 32'h0,        32'h0};
        vecs[12] = '{1'b0, F3_B,  32'h101, 32'h0,        32'h00007F00, 1'b0, 4'h2, 32'h0,        32'h0000007F};
        vecs[13] = '{1'b0, F3_HU, 32'h103, 32'h0,        32'h0,        1'b1, 4'h0, 32'h0,        32'h0};

        repeat (2) @(negedge clk);
        chk("rst_ready", {31'b0, lsu_ready}, 32'd1);
        chk("rst_flags", {28'b0, lsu_done, lsu_err, mem_req, mem_we}, 32'd0);
        chk("rst_load_data", load_data, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_be", {28'b0, mem_be}, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) run_vec(vecs[i]);

        // gnt held off 3 cycles; a second lsu_valid while busy must be ignored
        @(negedge clk);
        drive_req(1'b0, F3_W, 32'h300, 32'h0);
        e.err = 1'b0; e.load = 32'h11223344;
        sb_q.push_back(e);
        @(negedge clk);
        drive_req(1'b0, F3_W, 32'h404, 32'h0);
        for (int c = 0; c < 3; c++) begin
            chk("stall_req", {31'b0, mem_req}, 32'd1);
            chk("stall_addr", mem_addr, 32'h300);
            if (c == 2) lsu_valid = 1'b0;
            @(negedge clk);
        end
        chk("stall_req_last", {31'b0, mem_req}, 32'd1);
        mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h11223344;
        @(negedge clk);
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        chk("gnt_rvalid_done", {31'b0, lsu_done}, 32'd1);
        @(negedge clk);
        chk("busy_valid_ignored", {30'b0, mem_req, lsu_ready}, 32'd1);

        // rvalid while idle is ignored
        mem_rvalid = 1'b1;
        repeat (2) @(negedge clk);
        mem_rvalid = 1'b0;
        chk("idle_rvalid", {30'b0, lsu_done, lsu_ready}, 32'd1);

        // reset in WAIT drops the access; the late rvalid must not complete it
        drive_req(1'b0, F3_W, 32'h500, 32'h0);
        @(negedge clk);
        lsu_valid = 1'b0;
        mem_gnt   = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        chk("wait_busy", {30'b0, mem_req, lsu_ready}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_ready", {31'b0, lsu_ready}, 32'd1);
        chk("midrst_load_data", load_data, 32'd0);
        chk("midrst_mem_be", {28'b0, mem_be}, 32'd0);
        rst = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'hABABABAB;
        @(negedge clk);
        mem_rvalid = 1'b0;
        chk("late_rvalid_done", {31'b0, lsu_done}, 32'd0);
        @(negedge clk);
        chk("late_rvalid_idle", {30'b0, lsu_done, lsu_ready}, 32'd1);

`ifdef LSU_TIMEOUT_EN
        drive_req(1'b0, F3_W, 32'h600, 32'h0);
        e.err = 1'b1; e.load = 32'h0;
        sb_q.push_back(e);
        k = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            lsu_valid = 1'b0;
            if (lsu_done) begin
                k = c;
                break;
            end
        end
        chk("tmo_cycles", k, 32'd5);
        chk("tmo_req_dropped", {31'b0, mem_req}, 32'd0);
        @(negedge clk);
        mem_rvalid = 1'b1;
        @(negedge clk);
        mem_rvalid = 1'b0;
        chk("tmo_late_rvalid", {31'b0, lsu_done}, 32'd0);
`endif

        @(negedge clk);
        chk("sb_empty", sb_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
